adc_ser_emu: RTL and testbench
==============================

ADC_SER_EMU -- requirements
Module: adc_ser_emu

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of serial data lanes.
REQ-002 SHALL have parameter BITS, default 14, sample width per lane.
REQ-003 SHALL have parameter FRAME_LEN, default 16, CLK cycles per frame; FRAME_LEN >= BITS and even, else elaboration error.
REQ-004 SHALL have parameter LOAD_POS, default 7, frame count at which samples load; LOAD_POS < FRAME_LEN, else elaboration error.
REQ-005 SHALL have parameter SYNC_DLY, default 0, count value forced on ENC rise; SYNC_DLY < FRAME_LEN, else elaboration error.
REQ-006 SHALL have parameter LSB_FIRST, default 0, serial bit order (0 = MSB first).
REQ-007 SHALL have port CLK, input, 1 bit: the single clock (bit/DCO clock); all logic on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port ENC, input, 1 bit: encode clock, treated as asynchronous data and sampled by CLK.
REQ-010 SHALL have port DATA_IN, input, NUM_CH*BITS bits: parallel samples, lane n at [n*BITS +: BITS].
REQ-011 SHALL have port MODE, input, 2 bits: 0 = DATA_IN, 1 = ramp, 2 = PATTERN, 3 = all-zero.
REQ-012 SHALL have port PATTERN, input, BITS bits: fixed test word for MODE 2.
REQ-013 SHALL have port DATA_OUT, output, NUM_CH bits: serial lane outputs.
REQ-014 SHALL have port FCO, output, 1 bit: frame clock.
REQ-015 SHALL have port LOAD, output, 1 bit: one-cycle load strobe.
REQ-016 SHALL have port LOCKED, output, 1 bit: first ENC edge seen.
REQ-017 SHALL have port SYNC_ERR, output, 1 bit: sticky frame misalignment flag.

Function
REQ-018 SHALL synchronise ENC through a 2-flop shift register; enc_rise = stage0 & ~stage1.
REQ-019 SHALL keep frame counter cnt of width clog2(FRAME_LEN): enc_rise -> cnt = SYNC_DLY; else cnt+1, FRAME_LEN-1 wraps to 0.
REQ-020 SHALL drive FCO = (cnt >= FRAME_LEN/2), registered with cnt (for 16: equals cnt[3]).
REQ-021 SHALL drive LOAD = LOCKED & (cnt == LOAD_POS), from the current cnt; enc_rise in the same cycle does not suppress it.
REQ-022 SHALL set LOCKED on the first enc_rise; it clears only on RST.
REQ-023 SHALL keep one BITS-wide shift register per lane; when LOAD is high, load it with the MODE-selected word.
REQ-024 SHALL, when LOAD is low, shift the lane registers toward the output end, filling with 0.
REQ-025 SHALL drive DATA_OUT[n] = MSB of the lane register (LSB if LSB_FIRST); the first bit appears the cycle after LOAD.
REQ-026 SHALL, after BITS bits are shifted out, output 0 until the next LOAD (FRAME_LEN-BITS idle bits).
REQ-027 SHALL maintain a BITS-wide ramp counter incremented on each LOAD in every MODE, wrapping 2^BITS-1 to 0.
REQ-028 SHALL, in MODE 1, load lane n with (ramp + n) mod 2^BITS, using the ramp value before the increment.
REQ-029 SHALL sample MODE, DATA_IN and PATTERN only in the LOAD cycle; changes at other times do not affect the word in flight.
REQ-030 SHALL set SYNC_ERR when LOCKED and enc_rise occur while the natural next cnt != SYNC_DLY; it does not set on the locking edge and is sticky until RST.
REQ-031 SHALL keep frames aligned: with ENC period = FRAME_LEN CLK cycles, enc_rise always coincides with natural wrap to SYNC_DLY, and SYNC_ERR stays 0.

Reset
REQ-032 SHALL, on RST high at a CLK edge, clear the ENC sync flops, cnt, ramp, all lane registers, LOCKED and SYNC_ERR.
REQ-033 SHALL hold DATA_OUT=0, FCO=0, LOAD=0, LOCKED=0 and SYNC_ERR=0 the cycle after reset.
REQ-034 SHALL discard any word in flight on reset mid-frame; no LOAD occurs until the next enc_rise after RST deasserts.
REQ-035 SHALL keep DATA_OUT at 0 and LOAD low before LOCKED; cnt free-runs.

Verification
REQ-036 Defaults; ENC period 16 CLK; MODE 0; lane0 = 14'h2ABC -> after LOCKED, LOAD every 16 cycles; lane0 serialises 10101010111100 MSB-first then two 0s; FCO 8 high / 8 low; SYNC_ERR stays 0.
REQ-037 MODE 1, 5 frames -> lanes 0..3 carry 0,1,2,3, then 1,2,3,4, ...; preset ramp 14'h3FFF -> next ramp 0, lane3 = 2.
REQ-038 LSB_FIRST=1, MODE 2, PATTERN=14'h0001 -> DATA_OUT[n] = 1 in the first bit after LOAD, then 0 for 15 cycles.
REQ-039 Shorten one ENC period to 12 CLK -> SYNC_ERR=1 one cycle after the sync delay; stays 1 after further normal frames; RST clears it.
REQ-040 RST asserted 3 cycles after LOAD mid-word -> DATA_OUT=0, LOCKED=0 the next cycle; no LOAD until the next enc_rise; then the first word is complete and correct.
REQ-041 SYNC_DLY=3, enc_rise and cnt==LOAD_POS in the same cycle -> LOAD asserted that cycle; cnt=3 the next cycle.

Source files
------------

// File: rtl/adc_ser_emu.sv
// Serial ADC emulator. Frames are locked to the ENC rising edge. Each lane
// shifts out a BITS-wide word per frame, and the frame is padded with zeros.
module adc_ser_emu #(
  parameter int NUM_CH    = 4,
  parameter int BITS      = 14,
  parameter int FRAME_LEN = 16,
  parameter int LOAD_POS  = 7,
  parameter int SYNC_DLY  = 0,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENC,
  input  logic [NUM_CH*BITS-1:0] DATA_IN,
  input  logic [1:0]             MODE,
  input  logic [BITS-1:0]        PATTERN,
  output logic [NUM_CH-1:0]      DATA_OUT,
  output logic                   FCO,
  output logic                   LOAD,
  output logic                   LOCKED,
  output logic                   SYNC_ERR
);

  localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] HALF = CW'(FRAME_LEN / 2);
  localparam logic [CW-1:0] LPOS = CW'(LOAD_POS);
  localparam logic [CW-1:0] SDLY = CW'(SYNC_DLY);

  typedef enum logic [1:0] {
    MODE_DATA = 2'd0,
    MODE_RAMP = 2'd1,
    MODE_PAT  = 2'd2,
    MODE_ZERO = 2'd3
  } mode_e;

  if (BITS < 2) begin : g_bad_bits
    $error("adc_ser_emu: BITS must be at least 2");
  end
  if ((FRAME_LEN < BITS) || (FRAME_LEN % 2 != 0)) begin : g_bad_frame
    $error("adc_ser_emu: FRAME_LEN must be even and >= BITS");
  end
  if (LOAD_POS >= FRAME_LEN) begin : g_bad_load_pos
    $error("adc_ser_emu: LOAD_POS must be < FRAME_LEN");
  end
  if (SYNC_DLY >= FRAME_LEN) begin : g_bad_sync_dly
    $error("adc_ser_emu: SYNC_DLY must be < FRAME_LEN");
  end

  logic                         enc_s0;
  logic                         enc_s1;
  logic                         enc_rise;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                cnt_nat;
  logic [BITS-1:0]              ramp;
  logic [NUM_CH-1:0][BITS-1:0]  lane_q;
  logic [NUM_CH-1:0][BITS-1:0]  lane_word;

  assign enc_rise = enc_s0 & ~enc_s1;
  assign cnt_nat  = (cnt == LAST) ? '0 : cnt + CW'(1);

  // LOAD looks at the current count, so a sync edge in the same cycle
  // does not cancel the load.
  assign LOAD = LOCKED & (cnt == LPOS);
  assign FCO  = (cnt >= HALF);

  always_comb begin
    lane_word = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      case (mode_e'(MODE))
        MODE_DATA: lane_word[n] = DATA_IN[n*BITS +: BITS];
        MODE_RAMP: lane_word[n] = ramp + BITS'(n);
        MODE_PAT:  lane_word[n] = PATTERN;
        default:   lane_word[n] = '0;
      endcase
    end
  end

  always_comb begin
    DATA_OUT = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      DATA_OUT[n] = LSB_FIRST ? lane_q[n][0] : lane_q[n][BITS-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      enc_s0   <= 1'b0;
      enc_s1   <= 1'b0;
      cnt      <= '0;
      ramp     <= '0;
      lane_q   <= '0;
      LOCKED   <= 1'b0;
      SYNC_ERR <= 1'b0;
    end else begin
      enc_s0 <= ENC;
      enc_s1 <= enc_s0;
      cnt    <= enc_rise ? SDLY : cnt_nat;
      if (enc_rise) begin
        LOCKED <= 1'b1;
      end
      // Only an edge after lock can be misaligned.
      if (LOCKED && enc_rise && (cnt_nat != SDLY)) begin
        SYNC_ERR <= 1'b1;
      end
      if (LOAD) begin
        ramp <= ramp + BITS'(1);
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (LOAD) begin
          lane_q[n] <= lane_word[n];
        end else if (LSB_FIRST) begin
          lane_q[n] <= {1'b0, lane_q[n][BITS-1:1]};
        end else begin
          lane_q[n] <= {lane_q[n][BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_ser_emu.sv
// Directed bench for adc_ser_emu. Instance a uses the default parameters.
// Instance b is a 4-bit, LSB-first variant with SYNC_DLY=3.
module tb_adc_ser_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc;
  logic [1:0]  mode;
  logic [55:0] data_in_a;
  logic [13:0] pattern_a;
  logic [3:0]  data_out_a;
  logic        fco_a, load_a, locked_a, sync_err_a;
  logic [15:0] data_in_b;
  logic [3:0]  pattern_b;
  logic [3:0]  data_out_b;
  logic        fco_b, load_b, locked_b, sync_err_b;

  int checks   = 0;
  int failures = 0;
  int enc_ph     = 0;
  int enc_period = 16;
  bit enc_on     = 1'b0;

  always #5 clk = ~clk;

  adc_ser_emu dut_a (
    .CLK(clk), .RST(rst), .ENC(enc), .DATA_IN(data_in_a), .MODE(mode),
    .PATTERN(pattern_a), .DATA_OUT(data_out_a), .FCO(fco_a), .LOAD(load_a),
    .LOCKED(locked_a), .SYNC_ERR(sync_err_a)
  );

  adc_ser_emu #(.NUM_CH(4), .BITS(4), .FRAME_LEN(16), .LOAD_POS(7),
                .SYNC_DLY(3), .LSB_FIRST(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .ENC(enc), .DATA_IN(data_in_b), .MODE(mode),
    .PATTERN(pattern_b), .DATA_OUT(data_out_b), .FCO(fco_b), .LOAD(load_b),
    .LOCKED(locked_b), .SYNC_ERR(sync_err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One CLK cycle. ENC is driven high for the first half of its period.
  task automatic tick();
    @(negedge clk);
    if (enc_on) begin
      enc_ph = (enc_ph + 1 >= enc_period) ? 0 : enc_ph + 1;
      enc = (enc_ph < enc_period / 2);
    end else begin
      enc = 1'b0;
    end
  endtask

  task automatic start_enc();
    enc_period = 16;
    enc_ph     = 15;
    enc_on     = 1'b1;
  endtask

  task automatic wait_ph0();
    int n = 0;
    do begin
      tick();
      n++;
    end while (enc_ph != 0 && n < 40);
  endtask

  task automatic wait_load(input bit sel, input string tag);
    int n = 0;
    while ((sel ? load_b : load_a) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(sel ? load_b : load_a), 32'd1);
  endtask

  // Call this in a LOAD cycle. It records the 16 serial bits of every lane;
  // the first bit ends up in the MSB. It returns in the next LOAD cycle.
  task automatic collect(input int change_at, output logic [3:0][15:0] va,
                         output logic [3:0][15:0] vb, output logic [15:0] fv);
    va = '0;
    vb = '0;
    fv = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == change_at) begin
        mode = 2'd3;
        data_in_a[13:0] = 14'h1111;
      end
      tick();
      for (int n = 0; n < 4; n++) begin
        va[n] = {va[n][14:0], data_out_a[n]};
        vb[n] = {vb[n][14:0], data_out_b[n]};
      end
      fv = {fv[14:0], fco_a};
    end
  endtask

  initial begin
    logic [3:0][15:0] va, vb;
    logic [15:0] fv;
    logic [4:0]  lv;
    bit any_load, any_dout, any_lock, fco_seen;

    rst = 1'b1;
    enc = 1'b0;
    mode = 2'd0;
    data_in_a = {14'h3FFF, 14'h0000, 14'h1555, 14'h2ABC};
    pattern_a = 14'h1234;
    data_in_b = 16'hFFFF;
    pattern_b = 4'h1;

    // Reset state
    tick();
    tick();
    check_eq("rst_dout", 32'(data_out_a), 32'h0);
    check_eq("rst_fco", 32'(fco_a), 32'h0);
    check_eq("rst_load", 32'(load_a), 32'h0);
    check_eq("rst_locked", 32'(locked_a), 32'h0);
    check_eq("rst_sync_err", 32'(sync_err_a), 32'h0);

    // Before lock: no loads, lanes quiet, the counter still runs
    rst = 1'b0;
    any_load = 0; any_dout = 0; any_lock = 0; fco_seen = 0;
    repeat (20) begin
      tick();
      any_load |= load_a;
      any_dout |= (data_out_a != 0);
      any_lock |= locked_a;
      fco_seen |= fco_a;
    end
    check_eq("prelock_load", 32'(any_load), 32'h0);
    check_eq("prelock_dout", 32'(any_dout), 32'h0);
    check_eq("prelock_locked", 32'(any_lock), 32'h0);
    check_eq("prelock_fco_runs", 32'(fco_seen), 32'h1);

    // Lock and serialise DATA_IN; MODE/DATA_IN change mid-word
    start_enc();
    begin
      int n = 0;
      while (locked_a !== 1'b1 && n < 10) begin tick(); n++; end
    end
    check_eq("locked", 32'(locked_a), 32'h1);
    wait_load(1'b0, "first_load");
    collect(3, va, vb, fv);
    check_eq("m0_lane0", 32'(va[0]), 32'hAAF0);
    check_eq("m0_lane1", 32'(va[1]), 32'h5554);
    check_eq("m0_lane2", 32'(va[2]), 32'h0000);
    check_eq("m0_lane3", 32'(va[3]), 32'hFFFC);
    check_eq("fco_frame", 32'(fv), 32'hFF00);
    check_eq("load_period16", 32'(load_a), 32'h1);
    collect(-1, va, vb, fv);
    check_eq("m3_lane1", 32'(va[1]), 32'h0);
    check_eq("m3_lane3", 32'(va[3]), 32'h0);
    mode = 2'd2;
    collect(-1, va, vb, fv);
    check_eq("m2_lane0", 32'(va[0]), 32'h48D0);
    check_eq("m2_lane3", 32'(va[3]), 32'h48D0);
    check_eq("aligned_no_err", 32'(sync_err_a), 32'h0);

    // Ramp mode after a fresh reset
    rst = 1'b1; enc_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mode = 2'd1;
    start_enc();
    wait_load(1'b0, "ramp_load");
    for (int k = 0; k < 5; k++) begin
      collect(-1, va, vb, fv);
      for (int n = 0; n < 4; n++) begin
        check_eq($sformatf("ramp_f%0d_l%0d", k, n), 32'(va[n]), 32'((k + n) * 4));
      end
    end

    // One ENC period shortened to 12 cycles
    wait_ph0();
    enc_period = 12;
    wait_ph0();
    enc_period = 16;
    tick();
    check_eq("serr_rise_cycle", 32'(sync_err_a), 32'h0);
    tick();
    check_eq("serr_set", 32'(sync_err_a), 32'h1);
    repeat (48) tick();
    check_eq("serr_sticky", 32'(sync_err_a), 32'h1);
    check_eq("serr_still_locked", 32'(locked_a), 32'h1);
    rst = 1'b1; enc_on = 1'b0;
    tick();
    check_eq("serr_rst_clear", 32'(sync_err_a), 32'h0);
    rst = 1'b0;

    // Reset three cycles into a word
    mode = 2'd0;
    data_in_a = {14'h3FFF, 14'h0000, 14'h1555, 14'h2ABC};
    start_enc();
    wait_load(1'b0, "midrst_load");
    repeat (3) tick();
    rst = 1'b1; enc_on = 1'b0;
    tick();
    check_eq("midrst_dout", 32'(data_out_a), 32'h0);
    check_eq("midrst_locked", 32'(locked_a), 32'h0);
    rst = 1'b0;
    any_load = 0;
    repeat (20) begin
      tick();
      any_load |= load_a;
    end
    check_eq("midrst_no_load", 32'(any_load), 32'h0);
    start_enc();
    wait_load(1'b0, "relock_load");
    collect(-1, va, vb, fv);
    check_eq("relock_lane0", 32'(va[0]), 32'hAAF0);
    check_eq("relock_lane3", 32'(va[3]), 32'hFFFC);

    // Instance b: LSB-first pattern, then an ENC edge that lands on LOAD_POS
    rst = 1'b1; enc_on = 1'b0;
    tick(); tick();
    check_eq("b_rst_dout", 32'(data_out_b), 32'h0);
    check_eq("b_rst_locked", 32'(locked_b), 32'h0);
    rst = 1'b0;
    mode = 2'd2;
    pattern_b = 4'h1;
    start_enc();
    wait_load(1'b1, "b_load");
    collect(-1, va, vb, fv);
    check_eq("b_lsb_lane0", 32'(vb[0]), 32'h8000);
    check_eq("b_lsb_lane3", 32'(vb[3]), 32'h8000);
    wait_ph0();
    enc_period = 21;
    wait_ph0();
    enc_period = 16;
    tick();
    check_eq("b_load_on_rise", 32'(load_b), 32'h1);
    lv = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lv = {lv[3:0], load_b};
    end
    check_eq("b_cnt_forced_3", 32'(lv), 32'h01);
    check_eq("b_serr", 32'(sync_err_b), 32'h1);

    // Instance b ramp wrap (4-bit ramp)
    rst = 1'b1; enc_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mode = 2'd1;
    start_enc();
    wait_load(1'b1, "b_ramp_load");
    for (int k = 0; k < 17; k++) begin
      collect(-1, va, vb, fv);
      if (k == 0) begin
        check_eq("b_ramp0_l1", 32'(vb[1]), 32'h8000);
        check_eq("b_ramp0_l2", 32'(vb[2]), 32'h4000);
      end
      if (k == 15) begin
        check_eq("b_ramp15_l3", 32'(vb[3]), 32'h4000);
      end
      if (k == 16) begin
        check_eq("b_wrap_l0", 32'(vb[0]), 32'h0000);
        check_eq("b_wrap_l3", 32'(vb[3]), 32'hC000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
